// File: rtl/banco_reg_param.sv
// Parametrised register file: two asynchronous read ports and one synchronous byte-enabled write port.
// It adds a self-clearing reset sequence and a sticky illegal-write flag. Optional forwarding is enabled with BANCO_REG_BYPASS_EN.
module banco_reg_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    a1,
    input  logic [ADDR_W-1:0]    a2,
    input  logic [ADDR_W-1:0]    a3,
    input  logic [WIDTH-1:0]     wd3,
    input  logic                 we3,
    input  logic [WIDTH/8-1:0]   be3,
    output logic [WIDTH-1:0]     rd1,
    output logic [WIDTH-1:0]     rd2,
    output logic                 busy,
    output logic                 werr
);

    // state    | meaning
    // ST_CLEAR | zeroing one register per cycle, writes refused
    // ST_READY | normal register-file operation
    localparam int NBYTES = WIDTH / 8;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    generate
        if ((WIDTH % 8) != 0) begin : g_bad_width
            $error("banco_reg_param: WIDTH must be a multiple of 8");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("banco_reg_param: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_werr;
    logic [WIDTH-1:0]    r_mem [DEPTH];

    logic                w_ready;
    logic                w_wr_zero;
    logic                w_wr_ok;

    assign w_ready   = (r_state == ST_READY);
    assign w_wr_zero = ZERO_REG && (a3 == '0);
    assign w_wr_ok   = w_ready && we3 && !w_wr_zero;

    function automatic logic [WIDTH-1:0] f_merge(
        input logic [WIDTH-1:0]  old_v,
        input logic [WIDTH-1:0]  new_v,
        input logic [NBYTES-1:0] be
    );
        logic [WIDTH-1:0] v;
        v = old_v;
        for (int b = 0; b < NBYTES; b++) begin
            if (be[b]) begin
                v[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return v;
    endfunction

    // mem is left untouched while rst is high; the clear walk starts once it drops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_werr  <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= '0;
            if (we3) begin
                r_werr <= 1'b1;
            end
            if (r_cnt == LAST_IDX) begin
                r_state <= ST_READY;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (w_wr_ok) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be3[b]) begin
                    r_mem[a3][8*b +: 8] <= wd3[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd1 = '0;
        if (w_ready && !(ZERO_REG && (a1 == '0))) begin
            rd1 = r_mem[a1];
`ifdef BANCO_REG_BYPASS_EN
            if (we3 && (a1 == a3)) begin
                rd1 = f_merge(r_mem[a1], wd3, be3);
            end
`endif
        end
    end

    always_comb begin
        rd2 = '0;
        if (w_ready && !(ZERO_REG && (a2 == '0))) begin
            rd2 = r_mem[a2];
`ifdef BANCO_REG_BYPASS_EN
            if (we3 && (a2 == a3)) begin
                rd2 = f_merge(r_mem[a2], wd3, be3);
            end
`endif
        end
    end

`ifndef BANCO_REG_BYPASS_EN
    // f_merge is only needed for forwarding; keep it referenced so both builds elaborate alike
    logic [WIDTH-1:0] w_merge_unused;
    assign w_merge_unused = f_merge('0, wd3, be3);
    logic w_unused;
    assign w_unused = ^w_merge_unused;
`endif

    assign busy = (r_state == ST_CLEAR);
    assign werr = r_werr;

endmodule

// File: tb/tb_banco_reg_param.sv
// Directed bench for banco_reg_param (WIDTH=32, DEPTH=32, ZERO_REG=1).
// The expected value for a same-cycle read follows BANCO_REG_BYPASS_EN.
module tb_banco_reg_param;

    logic        clk;
    logic        rst;
    logic [4:0]  a1, a2, a3;
    logic [31:0] wd3;
    logic        we3;
    logic [3:0]  be3;
    logic [31:0] rd1, rd2;
    logic        busy, werr;

    int errors = 0;
    int checks = 0;

    banco_reg_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
        .we3(we3), .be3(be3), .rd1(rd1), .rd2(rd2), .busy(busy), .werr(werr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        a3 = a; wd3 = d; be3 = be; we3 = 1'b1;
        step();
        we3 = 1'b0; be3 = 4'h0;
    endtask

    // edges after rst falls until busy drops; 100 means the bound expired
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            n++;
            if (!busy) break;
        end
        if (busy) n = 100;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; we3 = 1'b0; be3 = 4'h0; a1 = 5'd5; a2 = 5'd3; a3 = 5'd0; wd3 = '0;
        step(); step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
        checks++; if (werr !== 1'b0) begin errors++; $display("FAIL reset_werr: got %b expected 0", werr); end
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_rd1: got %h expected 0", rd1); end
        checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL reset_rd2: got %h expected 0", rd2); end
        rst = 1'b0;
        count_busy(n);
        checks++; if (n !== 32) begin errors++; $display("FAIL reset_busy_len: got %0d expected 32", n); end
    endtask

    task automatic test_full_write();
        wr(5'd5, 32'hDEADBEEF, 4'hF);
        a1 = 5'd5; a2 = 5'd5; #1;
        checks++; if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL full_rd1: got %h expected deadbeef", rd1); end
        checks++; if (rd2 !== 32'hDEADBEEF) begin errors++; $display("FAIL full_rd2: got %h expected deadbeef", rd2); end
    endtask

    task automatic test_byte_en();
        wr(5'd5, 32'h11223344, 4'b0101);
        a1 = 5'd5; #1;
        checks++; if (rd1 !== 32'hDE22BE44) begin errors++; $display("FAIL byte_en: got %h expected de22be44", rd1); end
        wr(5'd5, 32'hFFFFFFFF, 4'b0000);
        checks++; if (rd1 !== 32'hDE22BE44) begin errors++; $display("FAIL be_zero_noop: got %h expected de22be44", rd1); end
        wr(5'd6, 32'hCAFEF00D, 4'b1000);
        a2 = 5'd6; #1;
        checks++; if (rd2 !== 32'hCA000000) begin errors++; $display("FAIL byte_en_top: got %h expected ca000000", rd2); end
        a1 = 5'd6; #1;
        checks++; if (rd1 !== rd2 || rd1 !== 32'hCA000000) begin errors++; $display("FAIL same_addr: got %h/%h expected ca000000", rd1, rd2); end
    endtask

    task automatic test_zero_reg();
        wr(5'd0, 32'hFFFFFFFF, 4'hF);
        a1 = 5'd0; a2 = 5'd0; #1;
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL zero_rd1: got %h expected 0", rd1); end
        checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL zero_rd2: got %h expected 0", rd2); end
        a3 = 5'd0; wd3 = 32'h12345678; be3 = 4'hF; we3 = 1'b1; #1;
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL zero_bypass: got %h expected 0", rd1); end
        we3 = 1'b0; be3 = 4'h0;
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_full, exp_part;
`ifdef BANCO_REG_BYPASS_EN
        exp_full = 32'hB;
        exp_part = 32'h0000560B;
`else
        exp_full = 32'hA;
        exp_part = 32'hB;
`endif
        wr(5'd9, 32'hA, 4'hF);
        a1 = 5'd9; a2 = 5'd9; a3 = 5'd9; wd3 = 32'hB; be3 = 4'hF; we3 = 1'b1; #1;
        checks++; if (rd1 !== exp_full) begin errors++; $display("FAIL same_cycle_rd1: got %h expected %h", rd1, exp_full); end
        checks++; if (rd2 !== exp_full) begin errors++; $display("FAIL same_cycle_rd2: got %h expected %h", rd2, exp_full); end
        step();
        we3 = 1'b0; be3 = 4'h0;
        checks++; if (rd1 !== 32'hB) begin errors++; $display("FAIL after_edge_rd1: got %h expected 0000000b", rd1); end
        wd3 = 32'h12345678; be3 = 4'b0010; we3 = 1'b1; #1;
        checks++; if (rd2 !== exp_part) begin errors++; $display("FAIL part_bypass_rd2: got %h expected %h", rd2, exp_part); end
        we3 = 1'b0; be3 = 4'h0; #1;
        checks++; if (rd2 !== 32'hB) begin errors++; $display("FAIL part_abort_rd2: got %h expected 0000000b", rd2); end
    endtask

    task automatic test_reset_clear();
        int n;
        wr(5'd1, 32'h01010101, 4'hF);
        wr(5'd31, 32'h31313131, 4'hF);
        a1 = 5'd31; #1;
        checks++; if (rd1 !== 32'h31313131) begin errors++; $display("FAIL preload31: got %h expected 31313131", rd1); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy(n);
        checks++; if (n !== 32) begin errors++; $display("FAIL clear_busy_len: got %0d expected 32", n); end
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i); #1;
            checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL sweep_rd1[%0d]: got %h expected 0", i, rd1); end
        end
    endtask

    task automatic test_write_during_clear();
        int n;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step(); step();
        a3 = 5'd7; wd3 = 32'h5; be3 = 4'hF; we3 = 1'b1;
        step();
        we3 = 1'b0; be3 = 4'h0;
        checks++; if (werr !== 1'b1) begin errors++; $display("FAIL werr_set: got %b expected 1", werr); end
        count_busy(n);
        checks++; if (n !== 29) begin errors++; $display("FAIL clear_rest_len: got %0d expected 29", n); end
        a1 = 5'd7; #1;
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL dropped_write: got %h expected 0", rd1); end
        wr(5'd7, 32'h77, 4'hF);
        checks++; if (werr !== 1'b1) begin errors++; $display("FAIL werr_sticky: got %b expected 1", werr); end
        checks++; if (rd1 !== 32'h77) begin errors++; $display("FAIL ready_write: got %h expected 00000077", rd1); end
        rst = 1'b1; we3 = 1'b1; a3 = 5'd7; be3 = 4'hF;
        step();
        checks++; if (werr !== 1'b0) begin errors++; $display("FAIL werr_rst_clear: got %b expected 0", werr); end
        step();
        checks++; if (werr !== 1'b0) begin errors++; $display("FAIL werr_rst_hold: got %b expected 0", werr); end
        rst = 1'b0; we3 = 1'b0; be3 = 4'h0;
        count_busy(n);
        checks++; if (n !== 32) begin errors++; $display("FAIL rst_we_busy_len: got %0d expected 32", n); end
        checks++; if (werr !== 1'b0) begin errors++; $display("FAIL werr_after_clear: got %b expected 0", werr); end
    endtask

    task automatic test_mid_clear();
        int n;
        wr(5'd20, 32'h20202020, 4'hF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy(n);
        checks++; if (n !== 32) begin errors++; $display("FAIL mid_busy_len: got %0d expected 32", n); end
        a1 = 5'd20; #1;
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL mid_cleared: got %h expected 0", rd1); end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_byte_en();
        test_zero_reg();
        test_same_cycle();
        test_reset_clear();
        test_write_during_clear();
        test_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
